// File: rtl/order_book_snapshot_reader.sv
// Avalon-MM read slave serving word slices of order-book entries from a shadow copy.
// Word 0 refetches the entry; a sticky stale flag records engine writes to the shadowed entry.
module order_book_snapshot_reader #(
    parameter int ENTRY_W   = 128,
    parameter int DATA_W    = 32,
    parameter int NUM_BOOKS = 4,
    parameter int LEVELS    = 8,
    localparam int WORDS    = ENTRY_W / DATA_W,
    localparam int WORD_W   = $clog2(WORDS),
    localparam int EA_W     = $clog2(NUM_BOOKS) + 1 + $clog2(LEVELS),
    localparam int ADDR_W   = EA_W + WORD_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               chipselect,
    input  logic               read,
    input  logic [ADDR_W-1:0]  address,
    output logic               waitrequest,
    output logic [DATA_W-1:0]  readdata,
    output logic               readdatavalid,
    output logic               mem_rd,
    output logic [EA_W-1:0]    mem_addr,
    input  logic [ENTRY_W-1:0] mem_rdata,
    input  logic               upd_valid,
    input  logic [EA_W-1:0]    upd_addr
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_RESP} state_t;

    state_t              state_reg;
    logic [ENTRY_W-1:0]  shadow_reg;
    logic [EA_W-1:0]     shadow_addr_reg;
    logic                shadow_valid_reg;
    logic                stale_reg;
    logic                stale_pend_reg;
    logic [15:0]         fetch_cnt_reg;
    logic [WORD_W-1:0]   word_reg;

    logic                req_space;
    logic [EA_W-1:0]     req_ea;
    logic [WORD_W-1:0]   req_word;
    logic                accept;
    logic                req_hit;
    logic                shadow_upd;
    logic                fetch_upd;
    logic [DATA_W-1:0]   status_word;

    assign {req_space, req_ea, req_word} = address;

    assign accept     = chipselect && read && (state_reg == S_IDLE);
    assign req_hit    = (req_word != '0) && shadow_valid_reg && (req_ea == shadow_addr_reg);
    assign shadow_upd = upd_valid && shadow_valid_reg && (upd_addr == shadow_addr_reg);
    // mem_addr holds the in-flight fetch address throughout FETCH and WAIT.
    assign fetch_upd  = upd_valid && (upd_addr == mem_addr);

    always_comb begin
        status_word           = '0;
        status_word[0]        = shadow_valid_reg;
        status_word[1]        = stale_reg;
        status_word[8 +: EA_W] = shadow_addr_reg;
        status_word[31:16]    = fetch_cnt_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= S_IDLE;
            waitrequest      <= 1'b0;
            readdata         <= '0;
            readdatavalid    <= 1'b0;
            mem_rd           <= 1'b0;
            mem_addr         <= '0;
            shadow_reg       <= '0;
            shadow_addr_reg  <= '0;
            shadow_valid_reg <= 1'b0;
            stale_reg        <= 1'b0;
            stale_pend_reg   <= 1'b0;
            fetch_cnt_reg    <= '0;
            word_reg         <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (shadow_upd)
                        stale_reg <= 1'b1;
                    if (accept) begin
                        waitrequest <= 1'b1;
                        if (req_space) begin
                            readdata      <= status_word;
                            readdatavalid <= 1'b1;
                            state_reg     <= S_RESP;
                        end else if (req_hit) begin
                            readdata      <= shadow_reg[req_word*DATA_W +: DATA_W];
                            readdatavalid <= 1'b1;
                            state_reg     <= S_RESP;
                        end else begin
                            mem_rd         <= 1'b1;
                            mem_addr       <= req_ea;
                            word_reg       <= req_word;
                            stale_pend_reg <= 1'b0;
                            state_reg      <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    mem_rd <= 1'b0;
                    if (fetch_upd)
                        stale_pend_reg <= 1'b1;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    // The RAM may return pre-update data if the engine hit this entry mid-fetch.
                    shadow_reg       <= mem_rdata;
                    shadow_addr_reg  <= mem_addr;
                    shadow_valid_reg <= 1'b1;
                    stale_reg        <= stale_pend_reg || fetch_upd;
                    if (fetch_cnt_reg != 16'hFFFF)
                        fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
                    readdata      <= mem_rdata[word_reg*DATA_W +: DATA_W];
                    readdatavalid <= 1'b1;
                    state_reg     <= S_RESP;
                end
                S_RESP: begin
                    if (shadow_upd)
                        stale_reg <= 1'b1;
                    readdatavalid <= 1'b0;
                    waitrequest   <= 1'b0;
                    state_reg     <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_order_book_snapshot_reader.sv
// Bench for order_book_snapshot_reader: directed scenarios plus randomized reads
// checked against a transaction-level model of the shadow, stale flag and fetch counter.
module tb_order_book_snapshot_reader;

    localparam int ENTRY_W = 128;
    localparam int DATA_W  = 32;
    localparam int EA_W    = 6;
    localparam int ADDR_W  = 9;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               chipselect = 1'b0;
    logic               read = 1'b0;
    logic [ADDR_W-1:0]  address = '0;
    logic               waitrequest;
    logic [DATA_W-1:0]  readdata;
    logic               readdatavalid;
    logic               mem_rd;
    logic [EA_W-1:0]    mem_addr;
    logic [ENTRY_W-1:0] mem_rdata = '0;
    logic               upd_valid = 1'b0;
    logic [EA_W-1:0]    upd_addr = '0;

    order_book_snapshot_reader #(
        .ENTRY_W(ENTRY_W), .DATA_W(DATA_W), .NUM_BOOKS(4), .LEVELS(8)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read),
        .address(address), .waitrequest(waitrequest), .readdata(readdata),
        .readdatavalid(readdatavalid), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .upd_valid(upd_valid), .upd_addr(upd_addr)
    );

    always #5 clk = ~clk;

    // Entry RAM: data appears one cycle after the read strobe.
    logic [ENTRY_W-1:0] ram [64];
    always @(posedge clk) begin
        if (mem_rd)
            mem_rdata <= ram[mem_addr];
    end

    // Transaction-level model of the reader's visible state.
    logic               m_valid;
    logic               m_stale;
    logic [EA_W-1:0]    m_addr;
    logic [ENTRY_W-1:0] m_data;
    int                 m_cnt;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] model_status();
        logic [15:0] c;
        c = 16'(m_cnt);
        return {c, 2'b00, m_addr, 6'b000000, m_stale, m_valid};
    endfunction

    task automatic model_clear();
        m_valid = 1'b0;
        m_stale = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_cnt   = 0;
    endtask

    // One host read; upd_cyc (1..3, 0 = none) injects an engine write in that cycle after acceptance.
    task automatic do_read(input logic [ADDR_W-1:0] addr, input int upd_cyc,
                           input logic [EA_W-1:0] uaddr, input string tag);
        logic            space;
        logic [EA_W-1:0] ea;
        logic [1:0]      wd;
        logic            miss;
        logic [31:0]     exp_data;
        logic [31:0]     got;
        logic [EA_W-1:0] seen_addr;
        int              exp_lat, cycles, rd_pulses;
        {space, ea, wd} = addr;
        miss    = !space && (wd == 2'd0 || !m_valid || ea != m_addr);
        exp_lat = miss ? 3 : 1;
        if (space)
            exp_data = model_status();
        else if (miss)
            exp_data = ram[ea][wd*32 +: 32];
        else
            exp_data = m_data[wd*32 +: 32];

        chipselect = 1'b1; read = 1'b1; address = addr;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        checks++;
        if (waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL %s waitrequest_after_accept: got %b want 1", tag, waitrequest);
        end
        cycles = 1; rd_pulses = 0; seen_addr = '0;
        while (1) begin
            if (mem_rd) begin
                rd_pulses++;
                seen_addr = mem_addr;
            end
            upd_valid = (cycles == upd_cyc);
            upd_addr  = uaddr;
            if (readdatavalid || cycles >= 8) break;
            @(posedge clk); #1;
            cycles++;
        end
        got = readdata;
        @(posedge clk); #1;
        upd_valid = 1'b0;

        checks++;
        if (cycles !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, cycles, exp_lat);
        end
        checks++;
        if (got !== exp_data) begin
            errors++;
            $display("FAIL %s readdata: got %h want %h", tag, got, exp_data);
        end
        checks++;
        if (rd_pulses !== (miss ? 1 : 0)) begin
            errors++;
            $display("FAIL %s mem_rd_pulses: got %0d want %0d", tag, rd_pulses, miss ? 1 : 0);
        end
        if (miss) begin
            checks++;
            if (seen_addr !== ea) begin
                errors++;
                $display("FAIL %s mem_addr: got %h want %h", tag, seen_addr, ea);
            end
        end
        checks++;
        if (readdatavalid !== 1'b0 || waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle: got rdv=%b wr=%b want 0 0", tag, readdatavalid, waitrequest);
        end

        if (miss) begin
            m_data  = ram[ea];
            m_addr  = ea;
            m_valid = 1'b1;
            m_stale = (upd_cyc == 1 || upd_cyc == 2) && uaddr == ea;
            if (m_cnt < 65535) m_cnt++;
        end
        if (upd_cyc == exp_lat && m_valid && uaddr == m_addr)
            m_stale = 1'b1;
        $display("read %s addr=%h %s data=%h lat=%0d", tag, addr,
                 space ? "status" : (miss ? "miss" : "hit"), got, cycles);
    endtask

    task automatic pulse_upd(input logic [EA_W-1:0] a);
        upd_valid = 1'b1; upd_addr = a;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        if (m_valid && a == m_addr) m_stale = 1'b1;
        $display("update entry=%h", a);
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if ({waitrequest, readdatavalid, mem_rd} !== 3'b000 || readdata !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL %s outputs_zero: got wr=%b rdv=%b rd=%b data=%h maddr=%h want all 0",
                     tag, waitrequest, readdatavalid, mem_rd, readdata, mem_addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;
        model_clear();
        @(posedge clk); #1;
        do_read(9'h100, 0, '0, "reset_status");
    endtask

    task automatic test_directed_fetch();
        ram[6'h0B] = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        for (int w = 0; w < 4; w++)
            do_read({1'b0, 6'h0B, 2'(w)}, 0, '0, "b1_bid_l3");
        do_read(9'h100, 0, '0, "status_after_fetch");
    endtask

    task automatic test_other_entry_miss();
        do_read({1'b0, 6'h2A, 2'd2}, 0, '0, "other_entry_w2");
        do_read({1'b0, 6'h2A, 2'd3}, 0, '0, "other_entry_w3");
        do_read(9'h1FF, 0, '0, "status_low_bits_set");
    endtask

    task automatic test_stale();
        pulse_upd(6'h2A);
        ram[6'h2A] = {$urandom, $urandom, $urandom, $urandom};
        do_read({1'b0, 6'h2A, 2'd1}, 0, '0, "stale_hit_old_data");
        do_read(9'h100, 0, '0, "stale_status");
        do_read({1'b0, 6'h2A, 2'd0}, 0, '0, "stale_refetch");
        pulse_upd(6'h11);
        do_read(9'h100, 0, '0, "stale_cleared_status");
    endtask

    task automatic test_stale_in_flight();
        do_read({1'b0, 6'h15, 2'd0}, 2, 6'h15, "upd_in_wait");
        do_read(9'h100, 0, '0, "status_after_wait_upd");
        do_read({1'b0, 6'h0B, 2'd0}, 1, 6'h15, "upd_other_in_fetch");
        do_read(9'h100, 0, '0, "status_after_other_upd");
        do_read({1'b0, 6'h0B, 2'd2}, 1, 6'h0B, "upd_in_hit_resp");
        do_read(9'h100, 0, '0, "status_after_resp_upd");
    endtask

    task automatic test_ignored();
        for (int i = 0; i < 4; i++) begin
            chipselect = (i >= 2); read = (i < 2); address = {1'b0, 6'h03, 2'd0};
            @(posedge clk); #1;
            checks++;
            if ({waitrequest, readdatavalid, mem_rd} !== 3'b000) begin
                errors++;
                $display("FAIL ignored_%0d: got wr=%b rdv=%b rd=%b want 0 0 0",
                         i, waitrequest, readdatavalid, mem_rd);
            end
            $display("ignored cs=%b read=%b", chipselect, read);
        end
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic test_random();
        logic [EA_W-1:0] cand [4];
        logic [EA_W-1:0] ea;
        logic [ADDR_W-1:0] a;
        cand[0] = 6'h0B; cand[1] = 6'h2A; cand[2] = 6'h15; cand[3] = 6'h3C;
        for (int n = 0; n < 150; n++) begin
            ea = cand[$urandom_range(3)];
            if ($urandom_range(7) == 0)
                a = 9'h100 | 9'($urandom_range(255));
            else
                a = {1'b0, ea, 2'($urandom_range(3))};
            if ($urandom_range(5) == 0)
                pulse_upd(cand[$urandom_range(3)]);
            if ($urandom_range(9) == 0)
                ram[cand[$urandom_range(3)]] = {$urandom, $urandom, $urandom, $urandom};
            do_read(a, $urandom_range(3), cand[$urandom_range(3)], "random");
        end
    endtask

    task automatic test_reset_mid_fetch();
        int seen;
        chipselect = 1'b1; read = 1'b1; address = {1'b0, 6'h3C, 2'd0};
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        checks++;
        if (mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL midfetch_in_fetch: got mem_rd=%b want 1", mem_rd);
        end
        reset = 1'b0;
        #1;
        check_outputs_zero("midfetch_reset");
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (readdatavalid) seen++;
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (readdatavalid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midfetch_no_response: got %0d pulses want 0", seen);
        end
        $display("reset during fetch, readdatavalid pulses=%0d", seen);
        model_clear();
        do_read(9'h100, 0, '0, "midfetch_status");
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            ram[i] = {$urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_directed_fetch();
        test_other_entry_miss();
        test_stale();
        test_stale_in_flight();
        test_ignored();
        test_random();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
